// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Program-counter owner for the 8-bit pipelined core. Drives the current PC
// into instruction_fetch, takes the decoded fields back and captures them in
// the IF/ID pipeline register. PC sequencing covers sequential fetch, taken
// jumps (opcode 2'b11, resolved in IF), stall hold, external redirect/flush
// and halting once the PC leaves the loaded program.
//
// Optional feature (macro FETCH_JUMP_COUNT_EN): adds a saturating 8-bit
// taken-jump counter on output jump_count.
//
// Parameters:
//   ADDR_W   - PC / instruction address width
//   PROG_LEN - number of valid instruction words; PC >= PROG_LEN halts.
//              PROG_LEN = 2**ADDR_W never halts (PC wraps).
//   RESET_PC - PC loaded on reset
//
// Ports:
//   clk, reset             - rising-edge clock, async active-high reset
//   stall_in               - hazard hold of IF and IF/ID
//   redirect_in/_addr      - later-stage redirect, flushes IF/ID
//   fetch_*                - fields decoded at instruction_address
//   instruction_address    - registered PC
//   if_id_*                - IF/ID register contents
//   halted                 - high while in HALT
//   jump_count             - taken jumps, saturating (optional)
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int PROG_LEN = 6,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              redirect_in,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic [1:0]        fetch_opcode,
  input  logic [2:0]        fetch_rDest,
  input  logic [2:0]        fetch_rSrc,
  input  logic [ADDR_W-1:0] fetch_jump_address,
  output logic [ADDR_W-1:0] instruction_address,
  output logic              if_id_valid,
  output logic [1:0]        if_id_opcode,
  output logic [2:0]        if_id_rDest,
  output logic [2:0]        if_id_rSrc,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic              halted
`ifdef FETCH_JUMP_COUNT_EN
  ,output logic [7:0]       jump_count
`endif
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [1:0] OP_JUMP = 2'b11;

  // One extra bit so PROG_LEN = 2**ADDR_W is representable and every
  // address compares as "inside the program".
  localparam logic [ADDR_W:0] LEN_W = (ADDR_W+1)'(PROG_LEN);

  function automatic logic in_prog(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < LEN_W);
  endfunction

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              vld_q;
  logic [1:0]        op_q;
  logic [2:0]        rdest_q;
  logic [2:0]        rsrc_q;
  logic [ADDR_W-1:0] ifpc_q;
  logic              halted_q;
`ifdef FETCH_JUMP_COUNT_EN
  logic [7:0]        jcnt_q;
`endif

  logic [ADDR_W-1:0] pc_inc_d;
  assign pc_inc_d = pc_q + ADDR_W'(1);  // wraps modulo 2**ADDR_W

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_BOOT;
      pc_q     <= ADDR_W'(RESET_PC);
      vld_q    <= 1'b0;
      op_q     <= '0;
      rdest_q  <= '0;
      rsrc_q   <= '0;
      ifpc_q   <= '0;
      halted_q <= 1'b0;
`ifdef FETCH_JUMP_COUNT_EN
      jcnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        // Instruction memory loads during this single cycle; nothing issues.
        S_BOOT: begin
          vld_q   <= 1'b0;
          state_q <= S_RUN;
          if (redirect_in) pc_q <= redirect_addr;
        end

        S_RUN: begin
          if (redirect_in) begin
            // Redirect wins over stall: the younger work in IF/ID is dead.
            pc_q  <= redirect_addr;
            vld_q <= 1'b0;
            if (!in_prog(redirect_addr)) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
          end else if (stall_in) begin
            // hold PC and IF/ID
          end else if (!in_prog(pc_q)) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
            vld_q    <= 1'b0;
          end else if (fetch_opcode == OP_JUMP) begin
            // Jump resolves in IF: fields are latched for visibility but the
            // slot is a bubble, so the jump itself never issues.
            pc_q    <= fetch_jump_address;
            vld_q   <= 1'b0;
            op_q    <= fetch_opcode;
            rdest_q <= fetch_rDest;
            rsrc_q  <= fetch_rSrc;
            ifpc_q  <= pc_q;
`ifdef FETCH_JUMP_COUNT_EN
            if (jcnt_q != 8'hFF) jcnt_q <= jcnt_q + 8'd1;
`endif
          end else begin
            pc_q    <= pc_inc_d;
            vld_q   <= 1'b1;
            op_q    <= fetch_opcode;
            rdest_q <= fetch_rDest;
            rsrc_q  <= fetch_rSrc;
            ifpc_q  <= pc_q;
          end
        end

        S_HALT: begin
          // Stall is ignored here; only a redirect can restart fetch.
          vld_q <= 1'b0;
          if (redirect_in) begin
            pc_q <= redirect_addr;
            if (in_prog(redirect_addr)) begin
              state_q  <= S_RUN;
              halted_q <= 1'b0;
            end
          end
        end

        default: begin
          state_q  <= S_BOOT;
          vld_q    <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign instruction_address = pc_q;
  assign if_id_valid         = vld_q;
  assign if_id_opcode        = op_q;
  assign if_id_rDest         = rdest_q;
  assign if_id_rSrc          = rsrc_q;
  assign if_id_pc            = ifpc_q;
  assign halted              = halted_q;
`ifdef FETCH_JUMP_COUNT_EN
  assign jump_count          = jcnt_q;
`endif

endmodule
